// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: drives the data-cache request, stalls upstream on a miss and
// registers the writeback bundle. Define ATOMIC_LLSC_EN to build in the ll/sc link register.
module mem_wb_stage (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ex_dren,
    input  logic        ex_dwen,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_store,
    input  logic [31:0] ex_aluout,
    input  logic        ex_regw,
    input  logic [4:0]  ex_wsel,
    input  logic        ex_halt,
    input  logic        ex_ll,
    input  logic        ex_sc,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    input  logic        snp_inv,
    input  logic [31:0] snp_addr,
    output logic        mem_stall,
    output logic        wb_regw,
    output logic [4:0]  wb_wsel,
    output logic [31:0] wb_wdat,
    output logic        wb_halt
);
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_t;

    state_t        state_q, state_d;
    logic          wb_regw_q, wb_regw_d;
    logic [RW-1:0] wb_wsel_q, wb_wsel_d;
    logic [DW-1:0] wb_wdat_q, wb_wdat_d;
    logic          wb_halt_q, wb_halt_d;

    logic active_c;
    logic sc_ok_c;
    logic req_c;
    logic stall_c;
    logic done_c;
    logic load_c;

`ifdef ATOMIC_LLSC_EN
    logic          link_valid_q, link_valid_d;
    logic [DW-1:0] link_addr_q, link_addr_d;

    assign sc_ok_c = link_valid_q && (link_addr_q == ex_addr);
`else
    logic unused_c;

    assign unused_c = ^{ex_ll, snp_inv, snp_addr};
    assign sc_ok_c  = 1'b1;
`endif

    // Requests are combinational; reset and HALTED kill them immediately.
    assign active_c  = nRST && (state_q != HALTED);
    assign req_c     = active_c && (ex_dren || ex_dwen) && !(ex_sc && !sc_ok_c);
    assign stall_c   = req_c && !dhit;
    assign done_c    = active_c && !stall_c;
    assign load_c    = ex_dren && !ex_dwen;

    assign dmemREN   = req_c && load_c;
    assign dmemWEN   = req_c && ex_dwen;
    assign dmemaddr  = ex_addr;
    assign dmemstore = ex_store;
    assign mem_stall = stall_c;

    assign wb_regw   = wb_regw_q;
    assign wb_wsel   = wb_wsel_q;
    assign wb_wdat   = wb_wdat_q;
    assign wb_halt   = wb_halt_q;

    // Next state and writeback bundle.
    always_comb begin
        state_d   = state_q;
        wb_regw_d = wb_regw_q;
        wb_wsel_d = wb_wsel_q;
        wb_wdat_d = wb_wdat_q;
        wb_halt_d = wb_halt_q;

        case (state_q)
            IDLE, WAIT: begin
                if (stall_c)      state_d = WAIT;
                else if (ex_halt) state_d = HALTED;
                else              state_d = IDLE;
            end
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase

        if (state_q == HALTED) begin
            wb_regw_d = 1'b0;
            wb_halt_d = 1'b1;
        end else if (stall_c) begin
            wb_regw_d = 1'b0;
            wb_halt_d = 1'b0;
        end else begin
            wb_regw_d = ex_regw;
            wb_wsel_d = ex_wsel;
            wb_halt_d = ex_halt;
            if (ex_sc)       wb_wdat_d = DW'(sc_ok_c);
            else if (load_c) wb_wdat_d = dmemload;
            else             wb_wdat_d = ex_aluout;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            wb_regw_q <= 1'b0;
            wb_wsel_q <= '0;
            wb_wdat_q <= '0;
            wb_halt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wb_regw_q <= wb_regw_d;
            wb_wsel_q <= wb_wsel_d;
            wb_wdat_q <= wb_wdat_d;
            wb_halt_q <= wb_halt_d;
        end
    end

`ifdef ATOMIC_LLSC_EN
    // Link register: a completing ll outranks any same-cycle invalidation.
    always_comb begin
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        if (done_c && ex_sc)
            link_valid_d = 1'b0;
        if (snp_inv && (snp_addr == link_addr_q))
            link_valid_d = 1'b0;
        if (dmemWEN && dhit && (ex_addr == link_addr_q))
            link_valid_d = 1'b0;
        if (done_c && ex_ll && load_c) begin
            link_valid_d = 1'b1;
            link_addr_d  = ex_addr;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end
`endif

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Clock and reset SHALL be: clock CLK; reset nRST, asynchronous, active-low.
REQ-002 CLK  in  1  rising-edge clock for all state.
REQ-003 nRST  in  1  asynchronous active-low reset.
REQ-004 Memory-op inputs SHALL be:
- ex_dren  in  1  load request, from the EX/MEM latch.
- ex_dwen  in  1  store request.
- ex_addr  in  32  data address (ALU result).
- ex_store  in  32  store data.
- ex_aluout  in  32  non-memory writeback value.
REQ-005 Control inputs SHALL be:
- ex_regw  in  1  register write.
- ex_wsel  in  5  destination register.
- ex_halt  in  1  halt marker.
- ex_ll  in  1  load-linked.
- ex_sc  in  1  store-conditional.
REQ-006 Cache-side signals SHALL be:
- dmemREN  out  1  read request.
- dmemWEN  out  1  write request.
- dmemaddr  out  32  request address.
- dmemstore  out  32  write data.
- dhit  in  1  access complete this cycle.
- dmemload  in  32  read data.
REQ-007 Snoop inputs SHALL be:
- snp_inv  in  1  remote invalidate.
- snp_addr  in  32  invalidated word address.
REQ-008 Stall and writeback outputs SHALL be:
- mem_stall  out  1  hold all upstream latches.
- wb_regw  out  1  register write.
- wb_wsel  out  5  destination register.
- wb_wdat  out  32  writeback data.
- wb_halt  out  1  halt retired.

Function
REQ-009 The block SHALL implement FSM states IDLE, WAIT, HALTED.
REQ-010 In IDLE with (ex_dren|ex_dwen)=1, dmemREN/dmemWEN SHALL equal ex_dren/ex_dwen combinationally, with dmemaddr=ex_addr and dmemstore=ex_store.
REQ-011 In IDLE, if dhit=1 in the request cycle the access SHALL complete that cycle; otherwise the FSM SHALL go to WAIT.
REQ-012 In WAIT, requests SHALL be held unchanged until dhit=1; on dhit the FSM SHALL return to IDLE.
REQ-013 mem_stall SHALL be (ex_dren|ex_dwen) & !dhit, outside HALTED and suppressed SC; mem_stall SHALL drop in the dhit cycle.
REQ-014 The writeback register SHALL latch on the edge where mem_stall=0, with latency of 1 cycle from completion to wb_* valid.
- wb_wdat SHALL be dmemload for loads, ex_aluout otherwise.
REQ-015 While mem_stall=1, the writeback register SHALL load a bubble (wb_regw=0, wb_halt=0; other fields don't-care).
REQ-016 When ex_halt=1 and mem_stall=0, wb_halt SHALL be set and the FSM SHALL enter HALTED.
REQ-017 HALTED SHALL be sticky until reset:
- dmemREN=dmemWEN=0.
- mem_stall=0.
- wb_regw=0.
- wb_halt held at 1.
REQ-018 Simultaneous ex_dren and ex_dwen SHALL be treated as a store; dmemREN SHALL be 0.

Reset
REQ-019 While nRST=0, the block SHALL force:
- FSM=IDLE, link valid=0.
- wb_regw=0, wb_wsel=0, wb_wdat=0, wb_halt=0.
REQ-020 Reset mid-WAIT SHALL abandon the access, and dmem requests SHALL deassert immediately because they are combinational from state.

Configuration
REQ-021 Macro ATOMIC_LLSC_EN SHALL compile the link register in or out.
REQ-022 With ATOMIC_LLSC_EN defined, link behaviour SHALL be:
- A completing ll load SHALL set link={valid=1, addr=ex_addr}.
- A completing ex_sc with valid and address match SHALL perform the store and write wb_wdat=1.
- A mismatched sc SHALL issue no request, no stall, and write wb_wdat=0.
- Any completing sc SHALL clear valid.
REQ-023 With ATOMIC_LLSC_EN defined, link valid SHALL clear when:
- snp_inv=1 and snp_addr==link addr, or
- a local store completes to the link address.
- Snoop and ll completion in the same cycle SHALL leave link set, since the ll wins.
REQ-024 Without ATOMIC_LLSC_EN, ll SHALL behave as a plain load and sc as a plain store writing wb_wdat=1.

Verification
REQ-025 Load with dhit=1 in the request cycle, dmemload=0xDEADBEEF, wsel=5 -> mem_stall never 1; next edge wb_regw=1, wb_wsel=5, wb_wdat=0xDEADBEEF.
REQ-026 Store with dhit delayed 3 cycles -> mem_stall=1 for 3 cycles, dmemWEN/addr/store held stable, 3 bubbles, then wb_regw=ex_regw.
REQ-027 ll 0x100, then sc 0x100 -> store issued, wb_wdat=1; a second sc 0x100 -> no dmemWEN, wb_wdat=0.
REQ-028 ll 0x100, snp_inv with snp_addr=0x100, then sc 0x100 -> no store, wb_wdat=0; with snp_addr=0x104 -> store, wb_wdat=1.
REQ-029 halt retires, then a load is presented -> wb_halt=1 sticky, dmemREN=0, mem_stall=0.
REQ-030 nRST asserted in WAIT -> dmemREN=0 and wb_* all 0 immediately; after release, the FSM reissues from IDLE.
